// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// ifetch_pkg : shared types and helpers for the instruction line arbiter
// Revision   : 1.0
// ============================================================================
package ifetch_pkg;

    localparam int LINE_BYTES = 16;
    localparam int OFFSET_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Operates on a 64-bit container so any address width up to 64 can use it.
    function automatic logic [63:0] line_align(input logic [63:0] addr);
        return {addr[63:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// rr_arb2  : two-input round-robin arbiter, one-hot grant, priority on grant
// Revision : 1.0
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_o  = 2'b00;
        prio_d = prio_q;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
        // Priority passes to the requester that did not just win.
        if (gnt_o[0]) begin
            prio_d = 1'b1;
        end else if (gnt_o[1]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifetch_line_arbiter.sv
`default_nettype none
// ============================================================================
// ifetch_line_arbiter : round-robin sharing of a fixed-latency 128-bit line
//                       memory; optional one-line repeat buffer via
//                       IFETCH_LINE_BUF_EN.
// Revision            : 1.0
// ============================================================================
module ifetch_line_arbiter
    import ifetch_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 128,
    parameter int MEM_BYTES   = 1024,
    parameter int MEM_LATENCY = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    output logic [1:0]        req_ready,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic              rsp_err,
    output logic [LINE_W-1:0] rsp_line,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_start,
    input  logic [LINE_W-1:0] mem_line
);

    localparam int                CNT_W     = $clog2(MEM_LATENCY);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(MEM_LATENCY - 1);
    localparam logic [ADDR_W-1:0] ERR_LIMIT = ADDR_W'(MEM_BYTES - 15);
    localparam int                TAG_W     = ADDR_W - OFFSET_W;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                id_q, id_d;
    logic                err_q, err_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_start_q, mem_start_d;

    logic [1:0]          w_gnt;
    logic                w_arb_en;
    logic                w_grant;
    logic                w_sel_id;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [63:0]         w_align64;
    logic                w_err;
    logic                w_hit;
    logic                w_capture;
    logic [LINE_W-1:0]   w_buf_line;

    assign w_arb_en   = (state_q == IDLE) && rst_n;
    assign w_grant    = |w_gnt;
    assign w_sel_id   = w_gnt[1];
    assign w_sel_addr = w_sel_id ? req_addr1 : req_addr0;
    assign w_align64  = line_align(64'(w_sel_addr));
    // Range check uses the unaligned byte address.
    assign w_err      = (w_sel_addr >= ERR_LIMIT);
    assign w_capture  = (state_q == WAIT) && !mem_start_q && (cnt_q == '0);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req_valid),
        .en_i  (w_arb_en),
        .gnt_o (w_gnt)
    );

`ifdef IFETCH_LINE_BUF_EN
    logic              buf_valid_q, buf_valid_d;
    logic [TAG_W-1:0]  buf_tag_q,   buf_tag_d;
    logic [LINE_W-1:0] buf_line_q,  buf_line_d;
    logic              nofill_q,    nofill_d;
    logic              w_unused;

    assign w_hit      = buf_valid_q && !flush && !w_err &&
                        (buf_tag_q == w_sel_addr[ADDR_W-1:OFFSET_W]);
    assign w_buf_line = buf_line_q;
    assign w_unused   = ^w_align64;

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_line_d  = buf_line_q;
        nofill_d    = nofill_q;
        if ((state_q == IDLE) && w_grant && !w_err && !w_hit) begin
            nofill_d = 1'b0;
        end
        // A flush while the access is outstanding keeps its line out of the buffer.
        if (flush) begin
            buf_valid_d = 1'b0;
            if (state_q == WAIT) begin
                nofill_d = 1'b1;
            end
        end
        if (w_capture && !nofill_d) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = mem_addr_q[ADDR_W-1:OFFSET_W];
            buf_line_d  = mem_line;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_line_q  <= '0;
            nofill_q    <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_line_q  <= buf_line_d;
            nofill_q    <= nofill_d;
        end
    end
`else
    logic w_unused;

    assign w_hit      = 1'b0;
    assign w_buf_line = '0;
    assign w_unused   = ^{flush, w_align64, TAG_W};
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        err_d       = err_q;
        line_d      = line_q;
        mem_addr_d  = mem_addr_q;
        mem_start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_grant) begin
                    id_d  = w_sel_id;
                    err_d = w_err;
                    if (w_err) begin
                        line_d  = '0;
                        state_d = RESP;
                    end else if (w_hit) begin
                        line_d  = w_buf_line;
                        state_d = RESP;
                    end else begin
                        mem_addr_d  = w_align64[ADDR_W-1:0];
                        mem_start_d = 1'b1;
                        state_d     = WAIT;
                    end
                end
            end
            WAIT: begin
                // Counter loads during the start cycle so capture lands MEM_LATENCY later.
                if (mem_start_q) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    line_d  = mem_line;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            id_q        <= 1'b0;
            err_q       <= 1'b0;
            line_q      <= '0;
            mem_addr_q  <= '0;
            mem_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            err_q       <= err_d;
            line_q      <= line_d;
            mem_addr_q  <= mem_addr_d;
            mem_start_q <= mem_start_d;
        end
    end

    assign req_ready = w_gnt;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_err   = err_q;
    assign rsp_line  = line_q;
    assign mem_addr  = mem_addr_q;
    assign mem_start = mem_start_q;

endmodule
`default_nettype wire
